ejector_sink: RTL and testbench
===============================

# ejector_sink

Packet sink attached to a router's Local output port; the receiving end of the request/grant/full handshake that PE injectors use toward the router. It accepts 32-bit packets from the router and checks the destination field against its own router ID. Accepted packets go into a small FIFO, which drains toward the PE at a fixed rate. It keeps saturating received and misrouted counters for simulation statistics.

## Interface
- `routerID`, 6'b000_000, own position: [5:3] = x, [2:0] = y.
- `dataWidth`, 32, packet width; fixed format {xDst[31:28], yDst[27:24], xSrc[23:20], ySrc[19:16], PacketID[15:6], ModuleID[5:0]}.
- `DEPTH`, 4, FIFO entries; power of two, minimum 2.
- `DRAIN_PERIOD`, 3, cycles between drain opportunities; minimum 1.
- `COUNT_W`, 16, width of the statistic counters.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `ReqUpStr`  in  1  router request; held with `PacketIn` stable until grant is seen.
- `PacketIn`  in  dataWidth  packet from the router.
- `GntUpStr`  out  1  one-cycle grant; packet captured.
- `UpStrFull`  out  1  FIFO full, so the router must not expect a grant.
- `PktValid`  out  1  one-cycle strobe: `PacketOut` holds a drained packet.
- `PacketOut`  out  dataWidth  drained packet; holds its value between strobes.
- `PktCount`  out  COUNT_W  packets accepted, saturating.
- `MisrouteCount`  out  COUNT_W  accepted packets whose destination is not this node, saturating.

## Operation
- Handshake FSM, three states: IDLE, ACCEPT, RELEASE.
- IDLE:
  - Condition `ReqUpStr && !UpStrFull`: go to ACCEPT and register `GntUpStr`=1.
  - At the same edge: write `PacketIn` to the FIFO and increment `PktCount`.
  - At the same edge, on misroute: increment `MisrouteCount`.
  - Otherwise stay in IDLE with `GntUpStr`=0.
- ACCEPT: `GntUpStr`←0 and go to RELEASE unconditionally. No second capture while the router still holds its request.
- RELEASE: go to IDLE when `ReqUpStr`=0; stay otherwise.
- Misroute test: `PacketIn[30:28] != routerID[5:3]` or `PacketIn[26:24] != routerID[2:0]`. Direction bits [31] and [27] are ignored.
- A misrouted packet is still accepted and queued.
- FIFO:
  - Circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap, plus an occupancy count from 0 to DEPTH.
  - `UpStrFull` = (count == DEPTH), combinational from the registered count.
- Drain:
  - Free-running counter `dcnt` counts 0..DRAIN_PERIOD-1 and wraps.
  - At the edge where `dcnt`=DRAIN_PERIOD-1, if the FIFO is non-empty: `PacketOut`←head, `PktValid`←1, and the pointer advances.
  - Otherwise `PktValid`←0.
- Push and pop on the same edge: both happen and count is unchanged. Push requires not-full, evaluated before the pop.
- Counters stick at all-ones and never wrap.

## Timing
- Reset (asynchronous, any time, including mid-handshake):
  - State=IDLE; `GntUpStr`, `PktValid`, `PacketOut`, `PktCount`, `MisrouteCount`, pointers, count and `dcnt` all go to 0.
  - FIFO contents are discarded; `UpStrFull`=0.
- Accept latency: Req sampled high at edge t with not-full → `GntUpStr` high from t to t+1, packet stored at t.
  - With a router that drops Req at t+1, the FSM is back in IDLE after edge t+2.
  - Minimum spacing between accepts is 3 cycles.
- `UpStrFull` rises the cycle after the push that fills the FIFO. It falls the cycle after a pop with no simultaneous push.
- Drain strobes come at most once every DRAIN_PERIOD cycles. With DRAIN_PERIOD=1, one strobe per cycle while non-empty.
- A packet accepted at edge t can drain no earlier than edge t+1.

## Test plan
- Single packet, routerID=6'b010_001:
  - Stimulus: PacketIn=32'hA1000405.
  - Required: one grant pulse; PktCount=1; MisrouteCount=0; PktValid pulse with PacketOut=32'hA1000405 within DRAIN_PERIOD cycles.
- Misroute:
  - Stimulus: PacketIn=32'h33000000 to routerID 6'b010_001.
  - Required: granted; MisrouteCount=1; packet still drained.
- Fill:
  - Setup: DRAIN_PERIOD=1000; Req held continuously.
  - Required: exactly 4 grants; UpStrFull=1 after the 4th push; no grant while full.
  - Required after the first drain: UpStrFull=0 and the 5th grant follows.
- Order/wrap:
  - Stimulus: 10 packets with PacketID 1..10 at DRAIN_PERIOD=3.
  - Required: drained in order 1..10; pointers wrap correctly; final count 0.
- Reset mid-handshake:
  - Stimulus: reset=0 in the ACCEPT state with 2 packets queued.
  - Required: immediately Gnt=0, UpStrFull=0, counters 0; no PktValid until new accepts.
- Saturation:
  - Setup: COUNT_W=4.
  - Stimulus: 20 accepted packets.
  - Required: PktCount=4'hF and it stays there.

Source files
------------

// File: rtl/ejector_sink.sv
// ejector_sink: packet sink on a router Local output port.
// Grants one packet per request/grant/release handshake, tags packets whose
// destination is not this node, queues everything in a small circular FIFO
// and drains the FIFO toward the PE once every DRAIN_PERIOD cycles.
module ejector_sink #(
  parameter logic [5:0] routerID     = 6'b000_000,
  parameter int         dataWidth    = 32,
  parameter int         DEPTH        = 4,
  parameter int         DRAIN_PERIOD = 3,
  parameter int         COUNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  output logic                 PktValid,
  output logic [dataWidth-1:0] PacketOut,
  output logic [COUNT_W-1:0]   PktCount,
  output logic [COUNT_W-1:0]   MisrouteCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam logic [DW-1:0] DLAST   = DW'(DRAIN_PERIOD - 1);
  localparam logic [CW-1:0] FULLCNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCEPT, RELEASE} state_t;

  state_t               state, nextState;
  logic [AW-1:0]        wrPtr, rdPtr;
  logic [CW-1:0]        count;
  logic [DW-1:0]        dcnt;
  logic [dataWidth-1:0] mem [DEPTH];
  logic                 doPush, doPop, misroute;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

  // Full flag straight from the registered occupancy.
  assign UpStrFull = (count == FULLCNT);

  // Direction bits 31 and 27 do not take part in the destination compare.
  assign misroute = (PacketIn[30:28] != routerID[5:3]) ||
                    (PacketIn[26:24] != routerID[2:0]);

  // Pop when the drain slot comes round and something is queued; the count
  // used here excludes a push on the same edge, so a packet never drains on
  // the edge that stores it.
  assign doPop = (dcnt == DLAST) && (count != '0);

  // Handshake state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next state and capture decision; only IDLE may capture, so a request the
  // router keeps holding after its grant is not taken twice.
  always_comb begin
    nextState = state;
    doPush    = 1'b0;
    case (state)
      IDLE: begin
        if (ReqUpStr && !UpStrFull) begin
          doPush    = 1'b1;
          nextState = ACCEPT;
        end
      end
      ACCEPT:  nextState = RELEASE;
      RELEASE: if (!ReqUpStr) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Grant pulse and statistic counters, all updated at the capture edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      GntUpStr      <= 1'b0;
      PktCount      <= '0;
      MisrouteCount <= '0;
    end else begin
      GntUpStr <= doPush;
      if (doPush) begin
        PktCount <= satInc(PktCount);
        if (misroute) MisrouteCount <= satInc(MisrouteCount);
      end
    end
  end

  // FIFO storage; contents need no reset because pointers and count do.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= PacketIn;
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Free-running drain slot counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              dcnt <= '0;
    else if (dcnt == DLAST)  dcnt <= '0;
    else                     dcnt <= dcnt + DW'(1);
  end

  // Output register: strobe for one cycle per drained packet, hold data otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PktValid  <= 1'b0;
      PacketOut <= '0;
    end else begin
      PktValid <= doPop;
      if (doPop) PacketOut <= mem[rdPtr];
    end
  end

endmodule

// File: tb/tb_ejector_sink.sv
// Directed bench for ejector_sink. Two instances share the router-side inputs:
// dutA drains every 3 cycles with 4-bit counters, dutB drains every 1000 cycles
// so its FIFO can be filled. Each test resets both before it starts.
module tb_ejector_sink;

  logic        clk;
  logic        reset;
  logic        ReqUpStr;
  logic [31:0] PacketIn;

  logic        gntA, fullA, pvA;
  logic [31:0] outA;
  logic [3:0]  cntA, misA;
  logic        gntB, fullB, pvB;
  logic [31:0] outB;
  logic [15:0] cntB, misB;

  int vectors;
  int miscompares;
  int gntCntA, gntCntB;
  logic [31:0] qA[$];
  logic [31:0] qB[$];

  ejector_sink #(.routerID(6'b010_001), .dataWidth(32), .DEPTH(4),
                 .DRAIN_PERIOD(3), .COUNT_W(4)) dutA (
    .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
    .GntUpStr(gntA), .UpStrFull(fullA), .PktValid(pvA), .PacketOut(outA),
    .PktCount(cntA), .MisrouteCount(misA));

  ejector_sink #(.routerID(6'b010_001), .dataWidth(32), .DEPTH(4),
                 .DRAIN_PERIOD(1000), .COUNT_W(16)) dutB (
    .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
    .GntUpStr(gntB), .UpStrFull(fullB), .PktValid(pvB), .PacketOut(outB),
    .PktCount(cntB), .MisrouteCount(misB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record grants and drained packets seen on each instance.
  always @(negedge clk) begin
    if (gntA) gntCntA = gntCntA + 1;
    if (gntB) gntCntB = gntCntB + 1;
    if (pvA) qA.push_back(outA);
    if (pvB) qB.push_back(outB);
  end

  function automatic logic [31:0] mkPkt(input int id);
    logic [31:0] p;
    p = 32'h2100_0000;
    p[15:6] = 10'(id);
    return p;
  endfunction

  task automatic doReset();
    ReqUpStr = 1'b0;
    PacketIn = '0;
    reset = 1'b0;
    @(negedge clk);
    gntCntA = 0; gntCntB = 0;
    qA.delete(); qB.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Router model: request, wait (bounded) for grant, drop request, then
  // leave two cycles so the sink is back in IDLE before the next request.
  task automatic send(input logic [31:0] pkt, input bit useB);
    bit got;
    got = 1'b0;
    PacketIn = pkt;
    ReqUpStr = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (useB ? gntB : gntA) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      $display("FAIL send_grant: pkt %h got no grant in 20 cycles, required a grant", pkt);
      miscompares++;
    end
    ReqUpStr = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; ReqUpStr = 1'b0; PacketIn = '0;
    @(negedge clk);
    vectors++; if (gntA !== 1'b0)  begin $display("FAIL rst_gnt: got %b need 0", gntA); miscompares++; end
    vectors++; if (fullA !== 1'b0) begin $display("FAIL rst_full: got %b need 0", fullA); miscompares++; end
    vectors++; if (pvA !== 1'b0)   begin $display("FAIL rst_pv: got %b need 0", pvA); miscompares++; end
    vectors++; if (outA !== 32'h0) begin $display("FAIL rst_out: got %h need 0", outA); miscompares++; end
    vectors++; if (cntA !== 4'h0)  begin $display("FAIL rst_cnt: got %h need 0", cntA); miscompares++; end
    vectors++; if (misA !== 4'h0)  begin $display("FAIL rst_mis: got %h need 0", misA); miscompares++; end
    vectors++; if (fullB !== 1'b0 || cntB !== 16'h0) begin
      $display("FAIL rst_B: full %b cnt %h need 0 0", fullB, cntB); miscompares++; end
  endtask

  task automatic test_single();
    doReset();
    send(32'hA100_0405, 1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (gntCntA != 1)   begin $display("FAIL single_gnts: got %0d need 1", gntCntA); miscompares++; end
    vectors++; if (cntA !== 4'h1)  begin $display("FAIL single_cnt: got %h need 1", cntA); miscompares++; end
    vectors++; if (misA !== 4'h0)  begin $display("FAIL single_mis: got %h need 0", misA); miscompares++; end
    vectors++; if (qA.size() != 1) begin $display("FAIL single_drains: got %0d need 1", qA.size()); miscompares++; end
    else begin
      vectors++; if (qA[0] !== 32'hA100_0405) begin
        $display("FAIL single_out: got %h need a1000405", qA[0]); miscompares++; end
    end
    vectors++; if (outA !== 32'hA100_0405) begin
      $display("FAIL single_hold: got %h need a1000405", outA); miscompares++; end
  endtask

  task automatic test_misroute();
    doReset();
    send(32'h3300_0000, 1'b0);
    vectors++; if (misA !== 4'h1) begin $display("FAIL mis_cnt: got %h need 1", misA); miscompares++; end
    // Direction bits 31 and 27 set, coordinates match: not a misroute.
    send(32'hA900_0000, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (gntCntA != 2)  begin $display("FAIL mis_gnts: got %0d need 2", gntCntA); miscompares++; end
    vectors++; if (misA !== 4'h1) begin $display("FAIL mis_dirbits: got %h need 1", misA); miscompares++; end
    vectors++; if (cntA !== 4'h2) begin $display("FAIL mis_pkts: got %h need 2", cntA); miscompares++; end
    vectors++; if (qA.size() != 2) begin $display("FAIL mis_drains: got %0d need 2", qA.size()); miscompares++; end
    else begin
      vectors++; if (qA[0] !== 32'h3300_0000) begin
        $display("FAIL mis_out: got %h need 33000000", qA[0]); miscompares++; end
    end
  endtask

  task automatic test_fill();
    bit got, prevFull, gntWhileFull, sawEmptySlot;
    doReset();
    for (int i = 1; i <= 4; i++) send(mkPkt(i), 1'b1);
    vectors++; if (fullB !== 1'b1) begin $display("FAIL fill_full: got %b need 1", fullB); miscompares++; end
    vectors++; if (gntCntB != 4)   begin $display("FAIL fill_gnts: got %0d need 4", gntCntB); miscompares++; end
    PacketIn = mkPkt(5);
    ReqUpStr = 1'b1;
    got = 1'b0; gntWhileFull = 1'b0; sawEmptySlot = 1'b0;
    prevFull = fullB;
    for (int i = 0; i < 1100 && !got; i++) begin
      @(negedge clk);
      if (gntB) begin
        got = 1'b1;
        if (prevFull) gntWhileFull = 1'b1;
      end else if (!fullB) sawEmptySlot = 1'b1;
      prevFull = fullB;
    end
    ReqUpStr = 1'b0;
    vectors++; if (!got) begin $display("FAIL fill_5th: no 5th grant in 1100 cycles, required one"); miscompares++; end
    vectors++; if (gntWhileFull) begin $display("FAIL fill_gntfull: grant while full got 1 need 0"); miscompares++; end
    vectors++; if (!sawEmptySlot) begin $display("FAIL fill_unfull: full never dropped before grant, got 0 need 1"); miscompares++; end
    vectors++; if (qB.size() != 1) begin $display("FAIL fill_drains: got %0d need 1", qB.size()); miscompares++; end
    else begin
      vectors++; if (qB[0] !== mkPkt(1)) begin $display("FAIL fill_head: got %h need %h", qB[0], mkPkt(1)); miscompares++; end
    end
    vectors++; if (fullB !== 1'b1) begin $display("FAIL fill_refull: got %b need 1", fullB); miscompares++; end
    vectors++; if (cntB !== 16'd5) begin $display("FAIL fill_cnt: got %0d need 5", cntB); miscompares++; end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_order();
    doReset();
    for (int i = 1; i <= 10; i++) send(mkPkt(i), 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (qA.size() != 10) begin $display("FAIL order_n: got %0d need 10", qA.size()); miscompares++; end
    for (int i = 0; i < 10 && i < qA.size(); i++) begin
      vectors++;
      if (qA[i] !== mkPkt(i + 1)) begin
        $display("FAIL order_pkt%0d: got %h need %h", i + 1, qA[i], mkPkt(i + 1)); miscompares++;
      end
    end
    vectors++; if (cntA !== 4'hA || fullA !== 1'b0) begin
      $display("FAIL order_end: cnt %h full %b need a 0", cntA, fullA); miscompares++; end
  endtask

  task automatic test_reset_mid();
    bit got;
    doReset();
    send(mkPkt(1), 1'b1);
    PacketIn = mkPkt(2);
    ReqUpStr = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gntB) got = 1'b1;
    end
    vectors++; if (!got) begin $display("FAIL rmid_gnt: no grant, required one"); miscompares++; end
    reset = 1'b0;
    #1;
    vectors++; if (gntB !== 1'b0)  begin $display("FAIL rmid_gnt0: got %b need 0", gntB); miscompares++; end
    vectors++; if (fullB !== 1'b0) begin $display("FAIL rmid_full: got %b need 0", fullB); miscompares++; end
    vectors++; if (cntB !== 16'h0 || misB !== 16'h0) begin
      $display("FAIL rmid_cnts: got %h %h need 0 0", cntB, misB); miscompares++; end
    ReqUpStr = 1'b0;
    @(negedge clk);
    qB.delete();
    reset = 1'b1;
    repeat (1050) @(negedge clk);
    vectors++; if (qB.size() != 0) begin $display("FAIL rmid_nodrain: got %0d strobes need 0", qB.size()); miscompares++; end
    vectors++; if (gntB !== 1'b0 || cntB !== 16'h0) begin
      $display("FAIL rmid_idle: gnt %b cnt %h need 0 0", gntB, cntB); miscompares++; end
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 1; i <= 20; i++) begin
      send(mkPkt(i), 1'b0);
      if (i >= 15) begin
        vectors++;
        if (cntA !== 4'hF) begin $display("FAIL sat_cnt%0d: got %h need f", i, cntA); miscompares++; end
      end
    end
    vectors++; if (gntCntA != 20) begin $display("FAIL sat_gnts: got %0d need 20", gntCntA); miscompares++; end
    vectors++; if (misA !== 4'h0) begin $display("FAIL sat_mis: got %h need 0", misA); miscompares++; end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    gntCntA = 0; gntCntB = 0;
    test_reset();
    test_single();
    test_misroute();
    test_fill();
    test_order();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
